// File: rtl/bus_pkg.sv
// Shared bus phase encodings, parameter defaults and the latched request record
// used by the multiplexed-address bus controller.
package bus_pkg;

  localparam logic [1:0] PH_IDLE    = 2'b00;
  localparam logic [1:0] PH_ADDR_LO = 2'b01;
  localparam logic [1:0] PH_ADDR_HI = 2'b10;
  localparam logic [1:0] PH_DATA    = 2'b11;

  localparam int         WAIT_LIMIT_DEF = 15;
  localparam logic [7:0] ABORT_DATA_DEF = 8'hFF;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_if.sv
// Core request/response handshake plus external pin bundle of the bus controller.
// master = controller side, slave = core/memory side.
interface bus_if;

  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic        rdy;
  logic [7:0]  addr_pins;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  data_oe;
  logic        rw_n;
  logic [1:0]  phase;

  modport master (
    input  req, req_we, req_addr, req_wdata, rdy, data_in,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           addr_pins, data_out, data_oe, rw_n, phase
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, rdy, data_in,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           addr_pins, data_out, data_oe, rw_n, phase
  );

endinterface

// File: rtl/wait_timer.sv
// 4-bit DATA-phase wait counter; expired flags the last allowed wait cycle.
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(LIMIT - 1);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 4'd0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/bus_controller.sv
// Sequences one core request into ADDR_LO / ADDR_HI / DATA bus phases on a
// multiplexed 8-bit bus, with rdy wait states and a timeout abort.
module bus_controller
  import bus_pkg::*;
#(
  parameter int         WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter logic [7:0] ABORT_DATA = ABORT_DATA_DEF
) (
  input  logic clk,
  input  logic rst,
  bus_if.master bus
);

  logic [1:0] state;
  logic [1:0] state_nx;
  bus_req_t   lat;
  logic       rsp_valid_q;
  logic       rsp_err_q;
  logic [7:0] rsp_rdata_q;

  logic in_data;
  logic expired;
  logic done;
  logic abort;

  assign in_data = (state == PH_DATA);
  assign done    = in_data && bus.rdy;
  assign abort   = in_data && !bus.rdy && expired;

  // Held clear outside DATA so every DATA entry starts counting from zero.
  wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_data),
    .enable  (in_data && !bus.rdy),
    .expired (expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      PH_IDLE:    if (bus.req) state_nx = PH_ADDR_LO;
      PH_ADDR_LO: state_nx = PH_ADDR_HI;
      PH_ADDR_HI: state_nx = PH_DATA;
      PH_DATA:    if (done || abort) state_nx = PH_IDLE;
      default:    state_nx = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PH_IDLE;
      lat         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state       <= state_nx;
      rsp_valid_q <= done || abort;
      if (state == PH_IDLE && bus.req) begin
        lat <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
      end
      // Response fields only change on completion so they hold between pulses.
      if (done) begin
        rsp_err_q <= 1'b0;
        if (!lat.we) rsp_rdata_q <= bus.data_in;
      end else if (abort) begin
        rsp_err_q <= 1'b1;
        if (!lat.we) rsp_rdata_q <= ABORT_DATA;
      end
    end
  end

  assign bus.phase     = state;
  assign bus.req_ready = (state == PH_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  always_comb begin
    bus.addr_pins = 8'h00;
    case (state)
      PH_ADDR_LO: bus.addr_pins = lat.addr[7:0];
      PH_ADDR_HI: bus.addr_pins = lat.addr[15:8];
      default:    bus.addr_pins = 8'h00;
    endcase
  end

  assign bus.rw_n     = (state == PH_IDLE) ? 1'b1 : !lat.we;
  assign bus.data_oe  = (in_data && lat.we) ? 8'hFF : 8'h00;
  assign bus.data_out = (in_data && lat.we) ? lat.wdata : 8'h00;

endmodule

// File: tb/tb_bus_controller.sv
// Directed-vector bench for bus_controller: per-phase pin checks inline, with
// responses checked by a separate scoreboard monitor against a queue.
module tb_bus_controller;

  localparam int WL = 15;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  bus_if bus();

  bus_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_phase"}, bus.phase, 2'b00);
    chk({tag, "_addr"}, bus.addr_pins, 8'h00);
    chk({tag, "_rw_n"}, bus.rw_n, 1'b1);
    chk({tag, "_oe"}, bus.data_oe, 8'h00);
    chk({tag, "_dout"}, bus.data_out, 8'h00);
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the response cycle.
  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                        input int lows, input logic [7:0] din, input logic hold,
                        input logic exp_err, input logic [7:0] exp_rdata);
    int ndata;
    chk_idle_pins("idle");
    bus.req       = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rdy       = 1'b0;
    @(negedge clk);
    chk("alo_phase", bus.phase, 2'b01);
    chk("alo_ready", bus.req_ready, 1'b0);
    chk("alo_addr", bus.addr_pins, addr[7:0]);
    chk("alo_rw_n", bus.rw_n, !we);
    chk("alo_oe", bus.data_oe, 8'h00);
    bus.req       = hold;
    bus.req_we    = !we;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    bus.rdy       = 1'b1;
    bus.data_in   = 8'h3C;
    @(negedge clk);
    chk("ahi_phase", bus.phase, 2'b10);
    chk("ahi_addr", bus.addr_pins, addr[15:8]);
    chk("ahi_rw_n", bus.rw_n, !we);
    chk("ahi_oe", bus.data_oe, 8'h00);
    chk("ahi_dout", bus.data_out, 8'h00);
    ndata = (lows >= WL) ? WL : lows + 1;
    for (int i = 0; i < ndata; i++) begin
      @(negedge clk);
      chk("data_phase", bus.phase, 2'b11);
      chk("data_addr", bus.addr_pins, 8'h00);
      chk("data_rw_n", bus.rw_n, !we);
      chk("data_oe", bus.data_oe, we ? 8'hFF : 8'h00);
      chk("data_dout", bus.data_out, we ? wdata : 8'h00);
      bus.rdy     = (i >= lows);
      bus.data_in = (i >= lows) ? din : ~din;
      if (i == ndata - 1) sbq.push_back('{err: exp_err, rdata: exp_rdata, cyc: cyc + 1});
    end
    @(negedge clk);
    bus.rdy     = 1'b0;
    bus.data_in = 8'hA5;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_idle_pins(tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'h00);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.rdy       = 1'b1;
    bus.data_in   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst0");
    rst     = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);

    do_txn(1'b0, 16'h12AB, 8'h00, 0,  8'h5A, 1'b0, 1'b0, 8'h5A);
    do_txn(1'b1, 16'hFFFE, 8'hC3, 0,  8'h00, 1'b0, 1'b0, 8'h5A);
    bus.req = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 16'h3407, 8'h00, 3,  8'h96, 1'b0, 1'b0, 8'h96);
    do_txn(1'b0, 16'hBEEF, 8'h00, 99, 8'h11, 1'b0, 1'b1, 8'hFF);
    do_txn(1'b1, 16'h0102, 8'h7E, 99, 8'h00, 1'b0, 1'b1, 8'hFF);
    do_txn(1'b0, 16'h0010, 8'h00, 0,  8'h21, 1'b1, 1'b0, 8'h21);
    do_txn(1'b1, 16'h0020, 8'h44, 0,  8'h00, 1'b1, 1'b0, 8'h21);
    do_txn(1'b0, 16'h0030, 8'h00, 0,  8'h63, 1'b0, 1'b0, 8'h63);
    do_txn(1'b0, 16'h4455, 8'h00, 14, 8'hE7, 1'b0, 1'b0, 8'hE7);
    @(negedge clk);

    // Reset during ADDR_HI with req held high: no response, no acceptance.
    bus.req      = 1'b1;
    bus.req_we   = 1'b0;
    bus.req_addr = 16'h9876;
    @(negedge clk);
    chk("rst_alo_phase", bus.phase, 2'b01);
    @(negedge clk);
    chk("rst_ahi_phase", bus.phase, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst1");
    rst     = 1'b0;
    bus.req = 1'b0;
    bus.rdy = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", bus.phase, 2'b00);
    for (int i = 0; i < 20; i++) @(negedge clk);
    bus.rdy = 1'b0;

    do_txn(1'b0, 16'hCAFE, 8'h00, 1, 8'h42, 1'b0, 1'b0, 8'h42);
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
